// File: rtl/hash_stream_serializer.sv
// Serializes 256-bit digests into OUT_WIDTH-bit beats with valid/ready and a last flag.
// One digest drains from the shifter while a second waits in the holding register.
module hash_stream_serializer #(
    parameter int OUT_WIDTH = 32,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [255:0]         hash_i,
    input  logic                 hash_valid_i,
    output logic                 hash_ready_o,
    output logic [OUT_WIDTH-1:0] dout_o,
    output logic                 dout_valid_o,
    input  logic                 dout_ready_i,
    output logic                 dout_last_o,
    output logic                 busy_o
);

    localparam int BEATS = 256 / OUT_WIDTH;
    localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

    generate
        if (!(OUT_WIDTH == 8 || OUT_WIDTH == 16 || OUT_WIDTH == 32 ||
              OUT_WIDTH == 64 || OUT_WIDTH == 128 || OUT_WIDTH == 256)) begin : g_bad_width
            $error("hash_stream_serializer: OUT_WIDTH must be 8, 16, 32, 64, 128 or 256");
        end
    endgenerate

    typedef enum logic {IDLE, SEND} state_t;

    state_t         state;
    logic [255:0]   shifter;
    logic [255:0]   hold_reg;
    logic           hold_full;
    logic [CW-1:0]  cnt;

    logic in_xfer;
    logic out_xfer;
    logic at_last;

    // The current beat always sits at the end of the shifter that leaves first.
    function automatic logic [255:0] shift_beat(input logic [255:0] v);
        if (MSB_FIRST)
            return v << OUT_WIDTH;
        else
            return v >> OUT_WIDTH;
    endfunction

    assign in_xfer      = hash_valid_i & hash_ready_o;
    assign out_xfer     = dout_valid_o & dout_ready_i;
    assign at_last      = (cnt == LAST_BEAT);
    assign dout_valid_o = (state == SEND);
    assign dout_last_o  = dout_valid_o & at_last;
    assign busy_o       = dout_valid_o | hold_full;

    generate
        if (MSB_FIRST) begin : g_msb
            assign dout_o = shifter[255 -: OUT_WIDTH];
        end else begin : g_lsb
            assign dout_o = shifter[OUT_WIDTH-1:0];
        end
    endgenerate

    // hash_ready_o tracks the next value of hold_full so it stays purely registered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            shifter      <= '0;
            hold_reg     <= '0;
            hold_full    <= 1'b0;
            cnt          <= '0;
            hash_ready_o <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (in_xfer) begin
                        shifter <= hash_i;
                        cnt     <= '0;
                        state   <= SEND;
                    end
                end
                SEND: begin
                    if (out_xfer && !at_last) begin
                        shifter <= shift_beat(shifter);
                        cnt     <= cnt + CW'(1);
                    end else if (out_xfer) begin
                        cnt <= '0;
                        if (hold_full) begin
                            shifter      <= hold_reg;
                            hold_full    <= 1'b0;
                            hash_ready_o <= 1'b1;
                        end else if (in_xfer) begin
                            shifter <= hash_i;
                        end else begin
                            state <= IDLE;
                        end
                    end
                    // A digest arriving on the final beat goes straight to the shifter instead.
                    if (in_xfer && !(out_xfer && at_last)) begin
                        hold_reg     <= hash_i;
                        hold_full    <= 1'b1;
                        hash_ready_o <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/hash_stream_serializer.md
Name: hash_stream_serializer

Overview:
- Downstream of the endianness-converted 256-bit digest; converts each digest into a stream of OUT_WIDTH-bit beats with a valid/ready handshake and a last flag.
- Holds up to two digests: one in the output shifter and one in a holding register. The core can therefore hand off the next digest while the current one drains.
- Back-to-back digests stream with no idle cycle between them.

Parameters:
- OUT_WIDTH, 32, output beat width. Legal values: 8, 16, 32, 64, 128, 256. Any other value is a compile-time error.
- MSB_FIRST, 1, beat order. 1: the first beat is hash_i[255 -: OUT_WIDTH]. 0: the first beat is hash_i[OUT_WIDTH-1:0].

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- hash_i  input  256  digest, already endianness-converted
- hash_valid_i  input  1  hash_i is valid
- hash_ready_o  output  1  block can accept a digest this cycle
- dout_o  output  OUT_WIDTH  current beat
- dout_valid_o  output  1  dout_o is valid
- dout_ready_i  input  1  sink accepts the beat
- dout_last_o  output  1  current beat is the final beat of its digest
- busy_o  output  1  at least one digest is held (shifter or holding register)

Behaviour:
- One clock, clk. Reset is synchronous and active-low on rst_n.
- BEATS = 256/OUT_WIDTH. The beat counter is $clog2(BEATS) bits wide, minimum 1 bit.
- Reset (rst_n=0 at a clk edge):
  - dout_o=0, dout_valid_o=0, dout_last_o=0, busy_o=0.
  - Holding register cleared, hold_full=0, beat counter=0, state=IDLE.
  - hash_ready_o is 1 from the first cycle after reset.
  - Reset mid-stream discards both digests; no partial beats after deassertion.
- Handshakes:
  - Input transfer: hash_valid_i & hash_ready_o.
  - Output transfer: dout_valid_o & dout_ready_i.
  - hash_ready_o = ~hold_full, driven from a register; it has no combinational path from hash_valid_i or dout_ready_i.
- State IDLE (shifter empty):
  - Input transfer: load the shifter, counter=0, go to SEND.
  - dout_valid_o=1 with beat 0 on the next cycle (1-cycle latency). The holding register stays empty.
- State SEND:
  - dout_o and dout_last_o come from the shifter/counter registers and stay stable while dout_valid_o=1 & dout_ready_i=0.
  - Non-final output transfer: shift by OUT_WIDTH, counter+1.
  - dout_last_o=1 exactly when counter==BEATS-1.
  - An input transfer during SEND writes the holding register; hold_full=1 from the next cycle, so hash_ready_o=0 from the next cycle.
- Final-beat transfer:
  - If hold_full=1: holding register → shifter, hold_full=0, counter=0, stay in SEND. dout_valid_o stays 1 (no bubble).
  - Else, if an input transfer happens in the same cycle: hash_i → shifter directly, stay in SEND, no bubble.
  - Else: go to IDLE, dout_valid_o=0 next cycle.
- Final-beat transfer with hold_full=1 and hash_valid_i=1: no input transfer, because hash_ready_o=0. The digest is accepted on a later cycle.
- OUT_WIDTH=256: BEATS=1. Every beat has dout_last_o=1 and the same chaining rules apply.
- busy_o = (state==SEND) | hold_full.
- Data ordering is a pure bit slice of hash_i. No byte swapping in this block.
- hash_i is sampled only on an input transfer. Changes at other times are ignored.

Test Plan:
- Reset then single digest: hash_i=256'h0001_0203_..._1E1F (bytes 00..1F MSB-first), OUT_WIDTH=32, MSB_FIRST=1, dout_ready_i=1 → 8 consecutive beats starting 1 cycle after accept: 32'h00010203, 32'h04050607, ..., 32'h1C1D1E1F. dout_last_o=1 on beat 8 only. dout_valid_o=0 after.
- Back-to-back: digests A then B offered continuously, ready=1 → 16 beats with no gap. hash_ready_o drops 1 cycle after B is accepted and rises 1 cycle after A's last beat. A third digest C is held off meanwhile.
- Backpressure: dout_ready_i toggles 1,0,0,1,... → dout_o and dout_last_o hold their value while ready=0. Sink receives the exact 8-beat sequence with no duplicates or skips.
- Same-cycle chain: hold empty, new digest offered in the cycle A's last beat transfers → B beat 0 is driven the next cycle, no bubble.
- MSB_FIRST=0, OUT_WIDTH=8, hash_i=256'h1F1E...0100 → 32 beats: 8'h00, 8'h01, ..., 8'h1F. last on 8'h1F.
- Reset mid-stream: rst_n=0 after beat 3 with hold_full=1 → next cycle all outputs 0 and hash_ready_o=1. A fresh digest then streams from its beat 0.
